// File: rtl/nes_joypad_target.sv
// nes_joypad_target: I2C target that emulates an NES Classic controller.
// A register-pointer write selects a report byte; reads return the 6-byte
// report built from a joypad snapshot taken when the read is addressed.
// SDA is open-drain (0 = pull low, 1 = release); SCL is never driven.
// Optional build macro NES_TARGET_FILTER_EN adds a FILTER_LEN-cycle
// stability filter on both bus lines after the synchronizer.
module nes_joypad_target #(
   parameter logic [6:0]  SLAVE_ADDR = 7'h52,
   parameter int unsigned FILTER_LEN = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_out,
   input  logic [7:0] joypad,
   output logic       busy,
   output logic       rd_done,
   output logic [2:0] ptr
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_WR_BYTE,
      ST_WR_ACK,
      ST_RD_BYTE,
      ST_RD_ACK,
      ST_IGNORE
   } state_t;

   // ------------------------------------------------------------------
   // Input conditioning. Index 1 carries SCL, index 0 carries SDA.
   // ------------------------------------------------------------------
   logic [1:0] lines_in;
   logic [1:0] meta_q;
   logic [1:0] sync_q;
   logic [1:0] line_q;

   assign lines_in = {scl_in, sda_in};

   // Two-flop synchronizer; an idle bus reads high on both lines.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_q <= 2'b11;
         sync_q <= 2'b11;
      end else begin
         meta_q <= lines_in;
         sync_q <= meta_q;
      end
   end

`ifdef NES_TARGET_FILTER_EN
   localparam int CNT_W = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_filt
         logic [CNT_W-1:0] cnt_q;
         logic             filt_q;

         // Accept a new level only after FILTER_LEN consecutive cycles at it.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               filt_q <= 1'b1;
               cnt_q  <= '0;
            end else if (sync_q[gi] == filt_q) begin
               cnt_q <= '0;
            end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
               filt_q <= sync_q[gi];
               cnt_q  <= '0;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end

         assign line_q[gi] = filt_q;
      end
   endgenerate
`else
   assign line_q = sync_q;
`endif

   // ------------------------------------------------------------------
   // Edge and bus-condition detection.
   // ------------------------------------------------------------------
   logic scl_c;
   logic sda_c;
   logic scl_prev_q;
   logic sda_prev_q;
   logic scl_rise;
   logic scl_fall;
   logic start_det;
   logic stop_det;

   assign scl_c = line_q[1];
   assign sda_c = line_q[0];

   // Previous conditioned levels for edge detection.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_prev_q <= scl_c;
         sda_prev_q <= sda_c;
      end
   end

   assign scl_rise  = scl_c & ~scl_prev_q;
   assign scl_fall  = ~scl_c & scl_prev_q;
   // SCL must be high both before and after the SDA transition.
   assign start_det = scl_c & scl_prev_q & sda_prev_q & ~sda_c;
   assign stop_det  = scl_c & scl_prev_q & ~sda_prev_q & sda_c;

   // ------------------------------------------------------------------
   // Report encoding, in the layout the joypad bridge decodes.
   // ------------------------------------------------------------------
   function automatic logic [7:0] report_byte(input logic [2:0] idx,
                                              input logic [7:0] j);
      logic [7:0] r;
      case (idx)
         3'd4:    r = {j[7], j[5], 1'b0, j[2], 1'b0, j[3], 2'b00};
         3'd5:    r = {1'b0, j[1], 1'b0, j[0], 2'b00, j[6], j[4]};
         3'd6,
         3'd7:    r = 8'hFF;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   // ------------------------------------------------------------------
   // Protocol state.
   // ------------------------------------------------------------------
   state_t     state_q;
   logic [6:0] shift_q;
   logic [2:0] bit_cnt_q;
   logic       rw_q;
   logic       ack_on_q;   // ACK phase: low is being driven for the 9th clock
   logic       load_q;     // read byte pending: next SCL fall drives bit 7
   logic [7:0] snap_q;
   logic       sda_out_q;
   logic       busy_q;
   logic       rd_done_q;
   logic [2:0] ptr_q;

   logic [7:0] shift_d;
   logic [2:0] bit_idx_d;
   logic [7:0] rd_byte;
   logic [7:0] entry_byte;

   assign shift_d    = {shift_q, sda_c};
   assign bit_idx_d  = bit_cnt_q - 3'd1;
   assign rd_byte    = report_byte(ptr_q, snap_q);
   // First byte of a read comes straight from the live vector being latched.
   assign entry_byte = report_byte(ptr_q, joypad);

   // Main FSM: START/STOP take priority over every state, then bit handling.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         rw_q      <= 1'b0;
         ack_on_q  <= 1'b0;
         load_q    <= 1'b0;
         snap_q    <= '0;
         sda_out_q <= 1'b1;
         busy_q    <= 1'b0;
         rd_done_q <= 1'b0;
         ptr_q     <= '0;
      end else begin
         rd_done_q <= 1'b0;
         if (start_det) begin
            state_q   <= ST_ADDR;
            bit_cnt_q <= '0;
            sda_out_q <= 1'b1;
            ack_on_q  <= 1'b0;
            load_q    <= 1'b0;
         end else if (stop_det) begin
            state_q   <= ST_IDLE;
            sda_out_q <= 1'b1;
            busy_q    <= 1'b0;
            ack_on_q  <= 1'b0;
            load_q    <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  sda_out_q <= 1'b1;
               end

               ST_IGNORE: begin
                  sda_out_q <= 1'b1;
               end

               ST_ADDR: begin
                  if (scl_rise) begin
                     shift_q   <= shift_d[6:0];
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     if (bit_cnt_q == 3'd7) begin
                        rw_q <= shift_d[0];
                        if (shift_d[7:1] == SLAVE_ADDR) begin
                           state_q  <= ST_ADDR_ACK;
                           busy_q   <= 1'b1;
                           ack_on_q <= 1'b0;
                        end else begin
                           state_q <= ST_IGNORE;
                           busy_q  <= 1'b0;
                        end
                     end
                  end
               end

               ST_ADDR_ACK,
               ST_WR_ACK: begin
                  if (scl_fall) begin
                     if (!ack_on_q) begin
                        sda_out_q <= 1'b0;
                        ack_on_q  <= 1'b1;
                     end else begin
                        ack_on_q <= 1'b0;
                        if ((state_q == ST_ADDR_ACK) && rw_q) begin
                           state_q   <= ST_RD_BYTE;
                           snap_q    <= joypad;
                           sda_out_q <= entry_byte[7];
                           bit_cnt_q <= 3'd7;
                           load_q    <= 1'b0;
                        end else begin
                           state_q   <= ST_WR_BYTE;
                           sda_out_q <= 1'b1;
                           bit_cnt_q <= '0;
                        end
                     end
                  end
               end

               ST_WR_BYTE: begin
                  if (scl_rise) begin
                     shift_q   <= shift_d[6:0];
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     if (bit_cnt_q == 3'd7) begin
                        ptr_q    <= shift_d[2:0];
                        state_q  <= ST_WR_ACK;
                        ack_on_q <= 1'b0;
                     end
                  end
               end

               ST_RD_BYTE: begin
                  if (scl_fall) begin
                     if (load_q) begin
                        sda_out_q <= rd_byte[7];
                        bit_cnt_q <= 3'd7;
                        load_q    <= 1'b0;
                     end else if (bit_cnt_q == 3'd0) begin
                        sda_out_q <= 1'b1;
                        state_q   <= ST_RD_ACK;
                     end else begin
                        bit_cnt_q <= bit_idx_d;
                        sda_out_q <= rd_byte[bit_idx_d];
                     end
                  end
               end

               ST_RD_ACK: begin
                  if (scl_rise) begin
                     ptr_q <= ptr_q + 3'd1;
                     if (!sda_c) begin
                        state_q <= ST_RD_BYTE;
                        load_q  <= 1'b1;
                     end else begin
                        rd_done_q <= 1'b1;
                        state_q   <= ST_IGNORE;
                     end
                  end
               end

               default: begin
                  state_q   <= ST_IDLE;
                  sda_out_q <= 1'b1;
               end
            endcase
         end
      end
   end

   assign sda_out = sda_out_q;
   assign busy    = busy_q;
   assign rd_done = rd_done_q;
   assign ptr     = ptr_q;

endmodule

// File: tb/tb_nes_joypad_target.sv
// Bench for nes_joypad_target: an I2C initiator model drives directed
// transactions, pushes expected bytes/ACKs/status into a scoreboard queue,
// and a monitor process pops and compares each observed DUT response.
module tb_nes_joypad_target;

   localparam int Q = 12;   // clk cycles per SCL quarter-phase

   logic       clk = 1'b0;
   logic       rst_n;
   logic       scl_m;
   logic       sda_m;
   logic       sda_bus;
   logic [7:0] joypad;
   logic       sda_out;
   logic       busy;
   logic       rd_done;
   logic [2:0] ptr;

   always #5 clk = ~clk;

   assign sda_bus = sda_m & sda_out;

   nes_joypad_target #(
      .SLAVE_ADDR (7'h52),
      .FILTER_LEN (4)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .scl_in  (scl_m),
      .sda_in  (sda_bus),
      .sda_out (sda_out),
      .joypad  (joypad),
      .busy    (busy),
      .rd_done (rd_done),
      .ptr     (ptr)
   );

   // Scoreboard
   string      exp_name_q[$];
   logic [7:0] exp_val_q[$];
   logic [7:0] obs_val_q[$];
   int         vectors     = 0;
   int         miscompares = 0;
   int         rd_cnt      = 0;
   int         low_cnt     = 0;

   always @(negedge clk) begin
      if (rd_done) rd_cnt++;
      if (!sda_out) low_cnt++;
   end

   task automatic expect_v(input string n, input logic [7:0] v);
      exp_name_q.push_back(n);
      exp_val_q.push_back(v);
   endtask

   task automatic observe(input logic [7:0] v);
      obs_val_q.push_back(v);
   endtask

   task automatic check_now(input string n, input logic [7:0] e, input logic [7:0] a);
      expect_v(n, e);
      observe(a);
   endtask

   // Monitor: compares every observed response with the oldest expectation.
   initial begin : monitor
      string      n;
      logic [7:0] e;
      logic [7:0] o;
      forever begin
         @(negedge clk);
         while (obs_val_q.size() > 0) begin
            o = obs_val_q.pop_front();
            vectors++;
            if (exp_val_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected-observation got %02h required none", o);
            end else begin
               n = exp_name_q.pop_front();
               e = exp_val_q.pop_front();
               if (o !== e) begin
                  miscompares++;
                  $display("FAIL %s got %02h required %02h", n, o, e);
               end else begin
                  $display("ok   %s = %02h", n, o);
               end
            end
         end
      end
   end

   task automatic hq(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_start();
      sda_m = 1'b1; scl_m = 1'b1; hq(Q);
      sda_m = 1'b0; hq(Q);
      scl_m = 1'b0; hq(Q);
   endtask

   task automatic bus_rstart();
      sda_m = 1'b1; hq(Q);
      scl_m = 1'b1; hq(Q);
      sda_m = 1'b0; hq(Q);
      scl_m = 1'b0; hq(Q);
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; hq(Q);
      scl_m = 1'b1; hq(Q);
      sda_m = 1'b1; hq(Q);
   endtask

   task automatic put_bit(input logic b);
      sda_m = b; hq(Q);
      scl_m = 1'b1; hq(Q);
      scl_m = 1'b0; hq(Q);
   endtask

   task automatic get_bit(output logic b);
      sda_m = 1'b1; hq(Q);
      scl_m = 1'b1; hq(Q / 2);
      b = sda_bus; hq(Q - Q / 2);
      scl_m = 1'b0; hq(Q);
   endtask

   task automatic wr_byte(input string n, input logic [7:0] v, input logic exp_ack);
      logic a;
      expect_v(n, {7'd0, exp_ack});
      for (int i = 7; i >= 0; i--) put_bit(v[i]);
      get_bit(a);
      observe({7'd0, a});
   endtask

   task automatic rd_byte(input string n, input logic [7:0] e, input logic nack);
      logic [7:0] v;
      logic       b;
      expect_v(n, e);
      for (int i = 7; i >= 0; i--) begin
         get_bit(b);
         v[i] = b;
      end
      observe(v);
      put_bit(nack);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int rd_base;
      int low_base;
      logic b;
      rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1; joypad = 8'h00;
      hq(5);
      check_now("reset-sda_out", 8'h01, {7'd0, sda_out});
      check_now("reset-busy",    8'h00, {7'd0, busy});
      check_now("reset-rd_done", 8'h00, {7'd0, rd_done});
      check_now("reset-ptr",     8'h00, {5'd0, ptr});
      rst_n = 1'b1;
      hq(5);

      // Write pointer 0 then read 6 bytes
      joypad = 8'b1000_0011;
      rd_base = rd_cnt;
      bus_start();
      wr_byte("t1-addr-w-ack", 8'hA4, 1'b0);
      wr_byte("t1-ptr-ack",    8'h00, 1'b0);
      bus_stop();
      bus_start();
      wr_byte("t1-addr-r-ack", 8'hA5, 1'b0);
      check_now("t1-busy", 8'h01, {7'd0, busy});
      rd_byte("t1-b0", 8'h00, 1'b0);
      rd_byte("t1-b1", 8'h00, 1'b0);
      rd_byte("t1-b2", 8'h00, 1'b0);
      rd_byte("t1-b3", 8'h00, 1'b0);
      rd_byte("t1-b4", 8'h80, 1'b0);
      rd_byte("t1-b5", 8'h50, 1'b1);
      bus_stop();
      check_now("t1-rd_done-count", 8'h01, 8'(rd_cnt - rd_base));
      check_now("t1-ptr",  8'h06, {5'd0, ptr});
      check_now("t1-busy-after-stop", 8'h00, {7'd0, busy});

      // Snapshot coherence
      joypad = 8'h00;
      bus_start();
      wr_byte("t2-addr-w-ack", 8'hA4, 1'b0);
      wr_byte("t2-ptr-ack",    8'h00, 1'b0);
      bus_stop();
      bus_start();
      wr_byte("t2-addr-r-ack", 8'hA5, 1'b0);
      rd_byte("t2-b0", 8'h00, 1'b0);
      rd_byte("t2-b1", 8'h00, 1'b0);
      joypad = 8'hFF;
      rd_byte("t2-b2", 8'h00, 1'b0);
      rd_byte("t2-b3", 8'h00, 1'b0);
      rd_byte("t2-b4", 8'h00, 1'b0);
      rd_byte("t2-b5", 8'h00, 1'b1);
      bus_stop();
      bus_start();
      wr_byte("t2-addr-w2-ack", 8'hA4, 1'b0);
      wr_byte("t2-ptr4-ack",    8'h04, 1'b0);
      bus_stop();
      bus_start();
      wr_byte("t2-addr-r2-ack", 8'hA5, 1'b0);
      rd_byte("t2-new-b4", 8'hD4, 1'b0);
      rd_byte("t2-new-b5", 8'h53, 1'b1);
      bus_stop();

      // Wrong address
      low_base = low_cnt;
      bus_start();
      wr_byte("t3-wrong-addr-nack", 8'hA6, 1'b1);
      check_now("t3-busy", 8'h00, {7'd0, busy});
      bus_stop();
      check_now("t3-sda-low-cycles", 8'h00, 8'(low_cnt - low_base));
      bus_start();
      wr_byte("t3-addr-w-ack", 8'hA4, 1'b0);
      wr_byte("t3-ptr-ack",    8'h00, 1'b0);
      bus_stop();

      // Repeated START
      joypad = 8'b1000_0011;
      bus_start();
      wr_byte("t4-addr-w-ack", 8'hA4, 1'b0);
      wr_byte("t4-ptr-ack",    8'h04, 1'b0);
      bus_rstart();
      wr_byte("t4-addr-r-ack", 8'hA5, 1'b0);
      rd_byte("t4-b4", 8'h80, 1'b0);
      rd_byte("t4-b5", 8'h50, 1'b1);
      bus_stop();
      check_now("t4-ptr", 8'h06, {5'd0, ptr});

      // Pointer wrap
      bus_start();
      wr_byte("t5-addr-w-ack", 8'hA4, 1'b0);
      wr_byte("t5-ptr-ack",    8'h07, 1'b0);
      bus_stop();
      bus_start();
      wr_byte("t5-addr-r-ack", 8'hA5, 1'b0);
      rd_byte("t5-b7", 8'hFF, 1'b0);
      rd_byte("t5-b0", 8'h00, 1'b0);
      rd_byte("t5-b1", 8'h00, 1'b1);
      bus_stop();
      check_now("t5-ptr", 8'h02, {5'd0, ptr});

      // Reset in the middle of a read byte while SDA is held low
      joypad = 8'h00;
      bus_start();
      wr_byte("t6-addr-w-ack", 8'hA4, 1'b0);
      wr_byte("t6-ptr-ack",    8'h04, 1'b0);
      bus_stop();
      bus_start();
      wr_byte("t6-addr-r-ack", 8'hA5, 1'b0);
      get_bit(b);
      get_bit(b);
      check_now("t6-sda-low-before-reset", 8'h00, {7'd0, sda_out});
      check_now("t6-busy-before-reset",    8'h01, {7'd0, busy});
      rst_n = 1'b0;
      @(negedge clk);
      check_now("t6-sda-released", 8'h01, {7'd0, sda_out});
      check_now("t6-busy-cleared", 8'h00, {7'd0, busy});
      check_now("t6-ptr-cleared",  8'h00, {5'd0, ptr});
      rst_n = 1'b1;
      hq(Q);
      bus_stop();
      bus_start();
      wr_byte("t6-after-reset-ack", 8'hA4, 1'b0);
      wr_byte("t6-after-ptr-ack",   8'h00, 1'b0);
      bus_stop();

`ifdef NES_TARGET_FILTER_EN
      // Short SDA glitch with SCL high must not register as START
      sda_m = 1'b0; hq(2);
      sda_m = 1'b1; hq(Q);
      scl_m = 1'b0; hq(Q);
      wr_byte("t7-glitch-no-start", 8'hA4, 1'b1);
      bus_stop();
`endif

      hq(10);
      vectors++;
      if (exp_val_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard-drain got %0d pending required 0", exp_val_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
